// File: rtl/sram_pkg.sv
// Shared types and helpers for the single-port SRAM array.
package sram_pkg;

  // Array controller states: zero-fill after reset, then normal service.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Address width for a given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-result pipeline: carries valid and data through READ_LATENCY stages.
// Data stages only load when their input is valid, so the output word holds
// the last read result between reads.
module sram_rd_pipe #(
  parameter int WIDTH        = 82,
  parameter int READ_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [READ_LATENCY:1]            vld_pipe;
  logic [READ_LATENCY:1][WIDTH-1:0] dat_pipe;

  // Shift valid every cycle; advance data only alongside a valid beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      if (in_vld) dat_pipe[1] <= in_data;
      for (int k = 2; k <= READ_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign out_vld  = vld_pipe[READ_LATENCY];
  assign out_data = dat_pipe[READ_LATENCY];

endmodule

// File: rtl/sram_sp_array.sv
// Single-port SRAM array with per-segment write mask, optional zero-fill
// after reset and a pipelined read path of 1 or 2 cycles.
module sram_sp_array
  import sram_pkg::*;
#(
  parameter int DEPTH         = 2,
  parameter int WIDTH         = 82,
  parameter int WAYS          = 2,
  parameter int READ_LATENCY  = 1,
  parameter int INIT_ON_RESET = 1,
  parameter int AW            = addr_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    RW0_addr,
  input  logic             RW0_en,
  input  logic             RW0_wmode,
  input  logic [WAYS-1:0]  RW0_wmask,
  input  logic [WIDTH-1:0] RW0_wdata,
  output logic [WIDTH-1:0] RW0_rdata,
  output logic             RW0_rvalid,
  output logic             ready
);

  localparam int            SEG  = WIDTH / WAYS;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t            state;
  logic [AW-1:0]     cnt;
  logic              rdy_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              in_range;
  logic              acc;
  logic              wr_acc;
  logic              rd_acc;
  logic [WIDTH-1:0]  rd_word;

  // Addresses past the last entry only exist for non-power-of-two depths.
  assign in_range = ({1'b0, RW0_addr} < (AW+1)'(DEPTH));
  assign acc      = RW0_en & rdy_q & ~reset;
  assign wr_acc   = acc & RW0_wmode & in_range;
  assign rd_acc   = acc & ~RW0_wmode;
  assign ready    = rdy_q;

  // Controller: walk cnt across the array once after reset, then serve.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt   <= '0;
      rdy_q <= (INIT_ON_RESET == 0);
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == LAST) begin
            state <= ST_RUN;
            rdy_q <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + AW'(1);
          end
        end
        ST_RUN:  rdy_q <= 1'b1;
        default: begin
          state <= ST_RUN;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  // Storage update: zero-fill during INIT, masked segment writes in RUN.
  // Nothing is written while reset is high so contents survive a reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        mem[cnt] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < WAYS; i++)
          if (RW0_wmask[i]) mem[RW0_addr][i*SEG +: SEG] <= RW0_wdata[i*SEG +: SEG];
      end
    end
  end

  // Read word; out-of-range addresses read back as zero.
  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = mem[RW0_addr];
  end

  sram_rd_pipe #(
    .WIDTH        (WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clock    (clock),
    .reset    (reset),
    .in_vld   (rd_acc),
    .in_data  (rd_word),
    .out_vld  (RW0_rvalid),
    .out_data (RW0_rdata)
  );

endmodule

// File: tb/tb_sram_sp_array.sv
// Scoreboard bench: two arrays share stimulus. A is DEPTH=4 / latency 1,
// B is DEPTH=3 / latency 2. Reads push hand-computed expectations with the
// cycle they are due; a negedge monitor pops on rvalid and checks data and
// timing, and flags unexpected or missing results.
module tb_sram_sp_array;

  localparam logic [81:0] ONES = {82{1'b1}};
  localparam logic [81:0] ZERO = '0;
  localparam logic [81:0] LO   = {41'b0, {41{1'b1}}};
  localparam logic [81:0] P55  = {41{2'b01}};

  typedef struct {
    logic [81:0] d;
    int          due;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [1:0]  addr;
  logic        en;
  logic        wmode;
  logic [1:0]  wmask;
  logic [81:0] wdata;
  logic [81:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;
  logic        ready_a, ready_b;

  int   cyc;
  int   n_chk;
  int   n_fail;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  sram_sp_array #(
    .DEPTH(4), .WIDTH(82), .WAYS(2), .READ_LATENCY(1), .INIT_ON_RESET(1)
  ) dut_a (
    .clock(clock), .reset(reset), .RW0_addr(addr), .RW0_en(en),
    .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
    .RW0_rdata(rdata_a), .RW0_rvalid(rvalid_a), .ready(ready_a)
  );

  sram_sp_array #(
    .DEPTH(3), .WIDTH(82), .WAYS(2), .READ_LATENCY(2), .INIT_ON_RESET(1)
  ) dut_b (
    .clock(clock), .reset(reset), .RW0_addr(addr), .RW0_en(en),
    .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
    .RW0_rdata(rdata_b), .RW0_rvalid(rvalid_b), .ready(ready_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [81:0] act, input logic [81:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard.
  always @(negedge clock) begin
    if (rvalid_a) begin
      if (qa.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_unexpected_rvalid: got data %h at cycle %0d, none expected", rdata_a, cyc);
      end else begin
        ea = qa.pop_front();
        check("a_rdata", rdata_a, ea.d);
        check_i("a_latency", cyc, ea.due);
      end
    end else if (qa.size() > 0 && qa[0].due < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL a_missing_rvalid: none by cycle %0d, required at %0d", cyc, qa[0].due);
      void'(qa.pop_front());
    end
    if (rvalid_b) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected_rvalid: got data %h at cycle %0d, none expected", rdata_b, cyc);
      end else begin
        eb = qb.pop_front();
        check("b_rdata", rdata_b, eb.d);
        check_i("b_latency", cyc, eb.due);
      end
    end else if (qb.size() > 0 && qb[0].due < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL b_missing_rvalid: none by cycle %0d, required at %0d", cyc, qb[0].due);
      void'(qb.pop_front());
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; wmode = 1'b0; wmask = 2'b00; wdata = '0;
    step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] m, input logic [81:0] d);
    en = 1'b1; wmode = 1'b1; addr = a; wmask = m; wdata = d;
    step();
  endtask

  task automatic rd(input logic [1:0] a, input logic [81:0] exp_a, input logic [81:0] exp_b,
                    input bit push_a = 1'b1, input bit push_b = 1'b1);
    en = 1'b1; wmode = 1'b0; addr = a; wmask = 2'b00; wdata = '0;
    if (push_a) qa.push_back('{d: exp_a, due: cyc + 1});
    if (push_b) qb.push_back('{d: exp_b, due: cyc + 2});
    step();
  endtask

  // After reset release: A not ready for 4 cycles, B for 3.
  task automatic init_window(input bit poke);
    for (int k = 1; k <= 4; k++) begin
      check("a_ready_init", {81'b0, ready_a}, 82'd0);
      check("b_ready_init", {81'b0, ready_b}, (k == 4) ? 82'd1 : 82'd0);
      en = 1'b0; wmode = 1'b0; wmask = 2'b00; wdata = '0;
      if (poke && k == 2) begin
        en = 1'b1; wmode = 1'b1; addr = 2'd0; wmask = 2'b11; wdata = ONES;
      end
      if (poke && k == 3) begin
        en = 1'b1; wmode = 1'b0; addr = 2'd1;
      end
      step();
    end
    check("a_ready_run", {81'b0, ready_a}, 82'd1);
    check("b_ready_run", {81'b0, ready_b}, 82'd1);
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0;
    reset = 1'b1; en = 1'b0; wmode = 1'b0; addr = '0; wmask = '0; wdata = '0;
    repeat (2) step();
    check("a_rdata_reset", rdata_a, ZERO);
    check("b_rdata_reset", rdata_b, ZERO);
    check("a_rvalid_reset", {81'b0, rvalid_a}, 82'd0);
    check("a_ready_reset", {81'b0, ready_a}, 82'd0);
    reset = 1'b0;
    init_window(1'b1);

    // Zero-filled array, back-to-back reads (B addr3 is out of range).
    rd(2'd0, ZERO, ZERO); rd(2'd1, ZERO, ZERO); rd(2'd2, ZERO, ZERO); rd(2'd3, ZERO, ZERO);
    idle();

    // Low-segment-only write.
    wr(2'd1, 2'b01, ONES);
    rd(2'd1, LO, LO);
    // Write then immediate read of the same entry.
    wr(2'd2, 2'b11, P55);
    rd(2'd2, P55, P55);
    // Out-of-range write on B is dropped; read returns zero with rvalid.
    wr(2'd3, 2'b11, ONES);
    rd(2'd3, ONES, ZERO);
    // Empty mask changes nothing.
    wr(2'd0, 2'b00, ONES);
    rd(2'd0, ZERO, ZERO);
    // Pipelined reads in mixed order.
    rd(2'd0, ZERO, ZERO); rd(2'd1, LO, LO); rd(2'd3, ONES, ZERO); rd(2'd2, P55, P55);
    repeat (3) idle();
    // Output holds across idle and across a write.
    wr(2'd1, 2'b10, ONES);
    idle(); idle();
    check("a_rdata_hold", rdata_a, P55);
    check("b_rdata_hold", rdata_b, P55);
    rd(2'd1, ONES, ONES);
    repeat (3) idle();

    // Reset with reads in flight: A's result already out, B's is dropped,
    // and the read issued alongside reset is ignored.
    rd(2'd1, ONES, ZERO, 1'b1, 1'b0);
    reset = 1'b1; en = 1'b1; wmode = 1'b0; addr = 2'd2;
    step();
    reset = 1'b0; en = 1'b0;
    check("a_rdata_flush", rdata_a, ZERO);
    check("b_rdata_flush", rdata_b, ZERO);
    check("b_rvalid_flush", {81'b0, rvalid_b}, 82'd0);
    check("a_ready_flush", {81'b0, ready_a}, 82'd0);

    // Reset again at cnt=2 of INIT: the full window restarts.
    idle(); idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    init_window(1'b0);

    // Everything zero-filled again.
    rd(2'd1, ZERO, ZERO); rd(2'd2, ZERO, ZERO); rd(2'd3, ZERO, ZERO);
    repeat (4) idle();

    check_i("a_queue_drained", qa.size(), 0);
    check_i("b_queue_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_sp_array.md
SRAM_SP_ARRAY -- requirements
Module: sram_sp_array

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of entries (>=2).
REQ-002 SHALL have parameter WIDTH, default 82, data bits per entry.
REQ-003 SHALL have parameter WAYS, default 2, mask segments; WIDTH divisible by WAYS, segment SEG=WIDTH/WAYS.
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal 1 or 2.
REQ-005 SHALL have parameter INIT_ON_RESET, default 1, 1 = zero-fill array after reset.
REQ-006 SHALL have derived constant AW = max(1, clog2(DEPTH)).
REQ-007 ports: clock  in  1  sole clock, all state updates on rising edge.
REQ-008 ports: reset  in  1  synchronous, active-high reset.
REQ-009 ports: RW0_addr  in  AW  entry address.
REQ-010 ports: RW0_en  in  1  access request.
REQ-011 ports: RW0_wmode  in  1  1 = write, 0 = read.
REQ-012 ports: RW0_wmask  in  WAYS  per-segment write enable.
REQ-013 ports: RW0_wdata  in  WIDTH  write data.
REQ-014 ports: RW0_rdata  out  WIDTH  read data.
REQ-015 ports: RW0_rvalid  out  1  one-cycle pulse, RW0_rdata carries new read result.
REQ-016 ports: ready  out  1  array accepts requests.

Function
REQ-017 State machine SHALL have states INIT and RUN; reset enters INIT if INIT_ON_RESET=1, else RUN.
REQ-018 In INIT an internal counter SHALL write all-zero to entry cnt each cycle, cnt 0..DEPTH-1, then enter RUN; INIT lasts exactly DEPTH cycles.
REQ-019 ready SHALL be 0 in INIT, 1 in RUN.
REQ-020 Requests (RW0_en=1) while ready=0 SHALL be ignored: no write, no rvalid.
REQ-021 Write (en=1, wmode=1, ready=1): for each i with wmask[i]=1, entry[addr] bits [i*SEG +: SEG] SHALL take wdata same segment at the clock edge; unmasked segments SHALL keep old value.
REQ-022 Write with wmask all-zero SHALL change no state and produce no rvalid.
REQ-023 Read (en=1, wmode=0, ready=1) in cycle T: RW0_rdata SHALL show entry[addr] as of edge T, and RW0_rvalid SHALL pulse, in cycle T+READ_LATENCY.
REQ-024 Reads SHALL be fully pipelined: one read per cycle, back-to-back results in order, one rvalid each.
REQ-025 Write to addr A in cycle T followed by read of A in T+1 SHALL return the written data (no stale read).
REQ-026 RW0_rdata SHALL hold its last read value between reads and across writes (no garbage, no random fill).
REQ-027 Address >= DEPTH (non-power-of-two DEPTH) SHALL be ignored for writes; reads SHALL return all-zero with rvalid.

Reset
REQ-028 Reset SHALL set RW0_rdata=0, RW0_rvalid=0, clear read pipeline, cnt=0.
REQ-029 ready SHALL be 0 during reset and the cycle after if INIT_ON_RESET=1; 1 the cycle after reset if INIT_ON_RESET=0.
REQ-030 Reset during INIT SHALL restart INIT from cnt=0; reset during in-flight reads SHALL drop them (no rvalid).
REQ-031 Array contents SHALL not be reset directly; with INIT_ON_RESET=0 they are unchanged by reset.

Structure
REQ-032 Package sram_pkg SHALL hold the state enum (INIT, RUN) and clog2-based AW helper.
REQ-033 The read pipeline SHALL be one sub-module sram_rd_pipe (parametrised WIDTH, READ_LATENCY), carrying valid and data.
REQ-034 Storage SHALL be a single WIDTH x DEPTH register/memory array, written per segment.

Verification
REQ-035 DEPTH=4, reset 1 cycle, INIT_ON_RESET=1 -> ready=0 for 4 cycles after reset release, then 1; reads of 0..3 return 0.
REQ-036 Write addr1 wdata=all-ones wmask=2'b01, then read addr1 -> rdata low 41 bits ones, high 41 bits 0, rvalid at T+1 (latency 1) / T+2 (latency 2).
REQ-037 Write addr2 0x155..., read addr2 in next cycle -> new data returned; reads addr0,1,2,3 back-to-back -> four rvalid pulses in order.
REQ-038 Request during INIT (write addr0 all-ones) -> ignored; later read addr0 returns 0.
REQ-039 Reset asserted mid-INIT at cnt=2 -> INIT restarts, ready low 4 more cycles; reset with read in flight -> no rvalid, rdata=0.
REQ-040 DEPTH=3: write addr3 -> no array change; read addr3 -> rdata=0, rvalid=1.
